// File: rtl/logic_pkg.sv
// Shared definitions for the logic issue pipe and logic_controller.
// Contents:
//   OPW       opcode width
//   op_e      opcode encoding, OP_NOP..OP_NOT
//   is_legal  1 for opcodes 0001..0111
//   uses_b    1 when the opcode reads a second operand (every op except NOT)
package logic_pkg;

  localparam int OPW = 4;

  typedef enum logic [OPW-1:0] {
    OP_NOP  = 4'b0000,
    OP_AND  = 4'b0001,
    OP_OR   = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_NAND = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_XNOR = 4'b0110,
    OP_NOT  = 4'b0111
  } op_e;

  // 0000 and every opcode with the top bit set are illegal.
  function automatic logic is_legal(input logic [OPW-1:0] op);
    return (op[OPW-1] == 1'b0) && (op != OP_NOP);
  endfunction

  function automatic logic uses_b(input logic [OPW-1:0] op);
    return (op != OP_NOT);
  endfunction

endpackage

// File: rtl/logic_regfile.sv
// Register file for the logic issue pipe.
// NREGS x WIDTH storage, two asynchronous read ports, two synchronous write
// ports. When both write ports hit the same entry at one edge, writeback wins
// and the load is dropped. Asynchronous active-high reset clears every entry.
// Ports:
//   clk, rst                  clock, async active-high reset
//   ra1/rd1, ra2/rd2          read address / read data
//   wb_en, wb_addr, wb_data   writeback port (higher priority)
//   ld_en, ld_addr, ld_data   direct load port
module logic_regfile
  import logic_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd2,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data
);

  logic [WIDTH-1:0] mem_r [NREGS];

  assign rd1 = mem_r[ra1];
  assign rd2 = mem_r[ra2];

  // Storage update: writeback takes priority over load on the same entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          mem_r[i] <= wb_data;
        end else if (ld_en && (ld_addr == AW'(i))) begin
          mem_r[i] <= ld_data;
        end
      end
    end
  end

endmodule

// File: rtl/logic_issue_pipe.sv
// Issue stage in front of logic_controller. Instructions enter over a
// valid/ready handshake, read their operands from logic_regfile, drive
// lu_opcode/lu_a/lu_b for one cycle (EX), and at the next edge the
// combinational lu_y is written back and reported on out_* (WB).
// Build option (macro LOGIC_ISSUE_BYPASS_EN):
//   defined     - an operand that depends on the op in EX is forwarded from lu_y
//   not defined - that instruction is held off one cycle (in_ready = 0)
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                instruction handshake
//   in_opcode, in_rd, in_rs1, in_rs2 instruction fields
//   ld_en, ld_addr, ld_data          direct register load
//   lu_opcode, lu_a, lu_b, lu_y      logic_controller interface
//   out_valid, out_rd, out_data, out_err  retirement report
//   err_sticky                       illegal opcode or load/writeback collision seen
module logic_issue_pipe
  import logic_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_opcode,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [OPW-1:0]   lu_opcode,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_y,
  output logic             out_valid,
  output logic [AW-1:0]    out_rd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             err_sticky
);

  logic             ex_valid_r;
  logic [OPW-1:0]   ex_op_r;
  logic [AW-1:0]    ex_rd_r;

  logic [WIDTH-1:0] rd1_s;
  logic [WIDTH-1:0] rd2_s;
  logic             ex_live_s;
  logic             haz_a_s;
  logic             haz_b_s;
  logic             hazard_s;
  logic             ready_s;
  logic             accept_s;
  logic             collision_s;
  logic [WIDTH-1:0] opa_s;
  logic [WIDTH-1:0] opb_s;

  logic_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .ra1     (in_rs1),
    .rd1     (rd1_s),
    .ra2     (in_rs2),
    .rd2     (rd2_s),
    .wb_en   (ex_live_s),
    .wb_addr (ex_rd_r),
    .wb_data (lu_y),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data)
  );

  // Only a legal op in EX produces a result that later readers depend on.
  assign ex_live_s   = ex_valid_r && is_legal(ex_op_r);
  assign haz_a_s     = ex_live_s && (in_rs1 == ex_rd_r);
  assign haz_b_s     = ex_live_s && uses_b(in_opcode) && (in_rs2 == ex_rd_r);
  assign hazard_s    = in_valid && (haz_a_s || haz_b_s);
  assign accept_s    = in_valid && ready_s;
  assign collision_s = ld_en && ex_live_s && (ld_addr == ex_rd_r);
  assign in_ready    = ready_s;

  // Operand selection and issue throttling for the EX dependency.
  always_comb begin
    opa_s   = rd1_s;
    opb_s   = rd2_s;
    ready_s = 1'b1;
`ifdef LOGIC_ISSUE_BYPASS_EN
    // lu_y already holds the value the EX op is about to write back.
    if (haz_a_s) begin
      opa_s = lu_y;
    end else begin
      opa_s = rd1_s;
    end
    if (haz_b_s) begin
      opb_s = lu_y;
    end else begin
      opb_s = rd2_s;
    end
`else
    // One bubble lets the EX result land in the regfile before the read.
    if (hazard_s) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
`endif
    if (!uses_b(in_opcode)) begin
      opb_s = '0;
    end else begin
      opb_s = opb_s;
    end
  end

  // EX stage: capture the accepted instruction; lu_* move only for legal ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= '0;
      ex_rd_r    <= '0;
      lu_opcode  <= '0;
      lu_a       <= '0;
      lu_b       <= '0;
    end else begin
      ex_valid_r <= accept_s;
      if (accept_s) begin
        ex_op_r <= in_opcode;
        ex_rd_r <= in_rd;
      end
      if (accept_s && is_legal(in_opcode)) begin
        lu_opcode <= in_opcode;
        lu_a      <= opa_s;
        lu_b      <= opb_s;
      end
    end
  end

  // WB stage: report retirement and accumulate the sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_rd     <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid <= ex_valid_r;
      if (ex_valid_r) begin
        out_rd   <= ex_rd_r;
        out_data <= ex_live_s ? lu_y : '0;
        out_err  <= !is_legal(ex_op_r);
      end
      if ((ex_valid_r && !is_legal(ex_op_r)) || collision_s) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule
